// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - condition evaluation, write-strobe gating, flag register and squash counter
module cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       cond,
    input  logic [3:0]       aluflags,
    input  logic [1:0]       flagw,
    input  logic             pcs,
    input  logic             regw,
    input  logic             memw,
    input  logic             nowrite,
    output logic             pcsrc,
    output logic             regwrite,
    output logic             memwrite,
    output logic             condex,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] squashcnt
);

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             n, z, c, v;

    assign {n, z, c, v} = flags_q;

    // Condition uses only the registered flags, so a flag-setting instruction
    // is judged against the flags that existed before it.
    always_comb begin
        condex = 1'b0;
        case (cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = c;
            4'b0011: condex = ~c;
            4'b0100: condex = n;
            4'b0101: condex = ~n;
            4'b0110: condex = v;
            4'b0111: condex = ~v;
            4'b1000: condex = c & ~z;
            4'b1001: condex = ~c | z;
            4'b1010: condex = (n == v);
            4'b1011: condex = (n != v);
            4'b1100: condex = ~z & (n == v);
            4'b1101: condex = z | (n != v);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    assign pcsrc    = en & pcs & condex;
    assign memwrite = en & memw & condex;
    assign regwrite = en & regw & condex & ~nowrite;

    always_comb begin
        flags_d = flags_q;
        if (en && condex && flagw[1]) flags_d[3:2] = aluflags[3:2];
        if (en && condex && flagw[0]) flags_d[1:0] = aluflags[1:0];
    end

    // Saturating count of instructions whose condition failed.
    always_comb begin
        cnt_d = cnt_q;
        if (en && !condex && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= RESET_FLAGS;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flags     = flags_q;
    assign squashcnt = cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - directed self-checking bench for cond_unit
module tb_cond_unit;

    logic        clk = 1'b0;
    logic        reset, en, pcs, regw, memw, nowrite;
    logic [3:0]  cond, aluflags;
    logic [1:0]  flagw;
    logic        pcsrc, regwrite, memwrite, condex;
    logic [3:0]  flags;
    logic [15:0] squashcnt;
    logic        pcsrc4, regwrite4, memwrite4, condex4;
    logic [3:0]  flags4;
    logic [3:0]  squashcnt4;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    cond_unit dut (
        .clk(clk), .reset(reset), .en(en), .cond(cond), .aluflags(aluflags),
        .flagw(flagw), .pcs(pcs), .regw(regw), .memw(memw), .nowrite(nowrite),
        .pcsrc(pcsrc), .regwrite(regwrite), .memwrite(memwrite), .condex(condex),
        .flags(flags), .squashcnt(squashcnt)
    );

    cond_unit #(.RESET_FLAGS(4'b1010), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .cond(cond), .aluflags(aluflags),
        .flagw(flagw), .pcs(pcs), .regw(regw), .memw(memw), .nowrite(nowrite),
        .pcsrc(pcsrc4), .regwrite(regwrite4), .memwrite(memwrite4), .condex(condex4),
        .flags(flags4), .squashcnt(squashcnt4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; cond = 4'b1110; aluflags = 0; flagw = 0;
        pcs = 0; regw = 0; memw = 0; nowrite = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step();
        n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got=%b exp=0000", flags); end
        n_cmp++; if (squashcnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", squashcnt); end
        n_cmp++; if (flags4 !== 4'b1010) begin n_bad++; $display("FAIL reset_flags4 got=%b exp=1010", flags4); end
        n_cmp++; if (squashcnt4 !== 4'd0) begin n_bad++; $display("FAIL reset_cnt4 got=%0d exp=0", squashcnt4); end
        // strobes remain combinational while reset is held
        en = 1; pcs = 1; regw = 1; memw = 1; #1;
        n_cmp++; if ({pcsrc, regwrite, memwrite} !== 3'b111) begin n_bad++; $display("FAIL reset_strobes got=%b exp=111", {pcsrc, regwrite, memwrite}); end
        en = 0; #1;
        n_cmp++; if ({pcsrc, regwrite, memwrite} !== 3'b000) begin n_bad++; $display("FAIL reset_stall_strobes got=%b exp=000", {pcsrc, regwrite, memwrite}); end
        idle();
        step();
        reset = 0;
    endtask

    task automatic test_flag_write();
        en = 1; cond = 4'b1110; flagw = 2'b11; aluflags = 4'b0100; #1;
        n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL no_bypass got=%b exp=0000", flags); end
        step();
        n_cmp++; if (flags !== 4'b0100) begin n_bad++; $display("FAIL flag_write got=%b exp=0100", flags); end
        flagw = 0; cond = 4'b0000; #1;
        n_cmp++; if (condex !== 1'b1) begin n_bad++; $display("FAIL cond_eq got=%b exp=1", condex); end
        cond = 4'b0001; #1;
        n_cmp++; if (condex !== 1'b0) begin n_bad++; $display("FAIL cond_ne got=%b exp=0", condex); end
        idle();
    endtask

    task automatic test_partial_write();
        en = 1; cond = 4'b1110; flagw = 2'b11; aluflags = 4'b1000;
        step();
        aluflags = 4'b0011; flagw = 2'b01;
        step();
        n_cmp++; if (flags !== 4'b1011) begin n_bad++; $display("FAIL partial_cv got=%b exp=1011", flags); end
        idle();
    endtask

    task automatic test_squash();
        en = 1; cond = 4'b1110; flagw = 2'b11; aluflags = 4'b0000;
        step();
        cond = 4'b0000; regw = 1; memw = 1; pcs = 1; flagw = 2'b11; aluflags = 4'b1111; #1;
        n_cmp++; if ({condex, pcsrc, regwrite, memwrite} !== 4'b0000) begin n_bad++; $display("FAIL squash_strobes got=%b exp=0000", {condex, pcsrc, regwrite, memwrite}); end
        step();
        n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL squash_flags got=%b exp=0000", flags); end
        n_cmp++; if (squashcnt !== 16'd1) begin n_bad++; $display("FAIL squash_cnt got=%0d exp=1", squashcnt); end
        idle();
    endtask

    task automatic test_cond_decode();
        en = 1; cond = 4'b1110; flagw = 2'b11; aluflags = 4'b1001;
        step();
        flagw = 0; cond = 4'b1010; #1;
        n_cmp++; if (condex !== 1'b1) begin n_bad++; $display("FAIL ge got=%b exp=1", condex); end
        cond = 4'b1100; #1;
        n_cmp++; if (condex !== 1'b1) begin n_bad++; $display("FAIL gt got=%b exp=1", condex); end
        cond = 4'b1110; flagw = 2'b11; aluflags = 4'b1000;
        step();
        flagw = 0; cond = 4'b1011; #1;
        n_cmp++; if (condex !== 1'b1) begin n_bad++; $display("FAIL lt got=%b exp=1", condex); end
        cond = 4'b1000; #1;
        n_cmp++; if (condex !== 1'b0) begin n_bad++; $display("FAIL hi got=%b exp=0", condex); end
        cond = 4'b1110; regw = 1; nowrite = 1; #1;
        n_cmp++; if (regwrite !== 1'b0) begin n_bad++; $display("FAIL nowrite got=%b exp=0", regwrite); end
        nowrite = 0; #1;
        n_cmp++; if (regwrite !== 1'b1) begin n_bad++; $display("FAIL regwrite got=%b exp=1", regwrite); end
        // own condition judged on pre-update flags: Z=0 fails, write dropped
        regw = 0; cond = 4'b0000; flagw = 2'b11; aluflags = 4'b0100;
        step();
        n_cmp++; if (flags !== 4'b1000) begin n_bad++; $display("FAIL pre_update got=%b exp=1000", flags); end
        n_cmp++; if (squashcnt !== 16'd2) begin n_bad++; $display("FAIL pre_update_cnt got=%0d exp=2", squashcnt); end
        idle();
    endtask

    task automatic test_saturate();
        reset = 1; step(); reset = 0;
        en = 1; cond = 4'b1111;
        for (int i = 0; i < 20; i++) step();
        n_cmp++; if (squashcnt4 !== 4'hF) begin n_bad++; $display("FAIL sat4 got=%h exp=F", squashcnt4); end
        n_cmp++; if (squashcnt !== 16'd20) begin n_bad++; $display("FAIL cnt20 got=%0d exp=20", squashcnt); end
        en = 0; pcs = 1; regw = 1; memw = 1; #1;
        n_cmp++; if ({pcsrc4, regwrite4, memwrite4} !== 3'b000) begin n_bad++; $display("FAIL stall_strobes got=%b exp=000", {pcsrc4, regwrite4, memwrite4}); end
        step(); step();
        n_cmp++; if (squashcnt4 !== 4'hF) begin n_bad++; $display("FAIL stall_sat4 got=%h exp=F", squashcnt4); end
        n_cmp++; if (squashcnt !== 16'd20) begin n_bad++; $display("FAIL stall_cnt got=%0d exp=20", squashcnt); end
        cond = 4'b1110; flagw = 2'b11; aluflags = 4'b1111; #1;
        n_cmp++; if (pcsrc !== 1'b0) begin n_bad++; $display("FAIL stall_pcsrc got=%b exp=0", pcsrc); end
        step();
        n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL stall_flags got=%b exp=0000", flags); end
        idle();
    endtask

    task automatic test_reset_collision();
        en = 1; cond = 4'b1111; step();
        reset = 1; en = 1; cond = 4'b1110; flagw = 2'b11; aluflags = 4'b1111;
        step();
        n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL coll_flags got=%b exp=0000", flags); end
        n_cmp++; if (flags4 !== 4'b1010) begin n_bad++; $display("FAIL coll_flags4 got=%b exp=1010", flags4); end
        n_cmp++; if (squashcnt !== 16'd0) begin n_bad++; $display("FAIL coll_cnt got=%0d exp=0", squashcnt); end
        reset = 0; idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_flag_write();
        test_partial_write();
        test_squash();
        test_cond_decode();
        test_saturate();
        test_reset_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have parameter RESET_FLAGS, default 4'b0000, giving the {N,Z,C,V} value loaded into the flag register on reset.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the squashed-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: instruction-advance enable; low = stall, all state held.
REQ-006 SHALL have port cond, input, 4 bits: instruction condition field.
REQ-007 SHALL have port aluflags, input, 4 bits: ALU flags {N,Z,C,V} from the current instruction.
REQ-008 SHALL have port flagw, input, 2 bits: flag write request; bit1 = N,Z, bit0 = C,V.
REQ-009 SHALL have ports pcs, regw, memw, input, 1 bit each: decoder PC-write, register-write and memory-write requests.
REQ-010 SHALL have port nowrite, input, 1 bit: suppress register write (compare-type instructions).
REQ-011 SHALL have ports pcsrc, regwrite, memwrite, output, 1 bit each: gated write strobes.
REQ-012 SHALL have port condex, output, 1 bit: the condition passed.
REQ-013 SHALL have port flags, output, 4 bits: current flag register {N,Z,C,V}.
REQ-014 SHALL have port squashcnt, output, CNT_W bits: count of condition-failed instructions.

Function
REQ-015 SHALL evaluate condex combinationally from cond and the registered flags (not aluflags).
REQ-016 SHALL decode cond as follows: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 always 1; 1111 always 0.
REQ-017 SHALL drive pcsrc = pcs & condex, memwrite = memw & condex, and regwrite = regw & condex & !nowrite, all combinationally.
REQ-018 SHALL hold pcsrc, regwrite and memwrite at 0 while en = 0, regardless of other inputs.
REQ-019 SHALL load flags[3:2] from aluflags[3:2] on a rising edge where en & condex & flagw[1] is true.
REQ-020 SHALL load flags[1:0] from aluflags[1:0] on a rising edge where en & condex & flagw[0] is true.
REQ-021 SHALL leave each flag pair unchanged in any cycle whose write condition (REQ-019, REQ-020) is false.
REQ-022 SHALL make a flag update visible on flags and in condex only from the cycle after the write, so there is no same-cycle bypass.
REQ-023 SHALL increment squashcnt by 1 on each rising edge with en = 1 and condex = 0.
REQ-024 SHALL saturate squashcnt at all-ones; it SHALL NOT wrap.
REQ-025 SHALL hold squashcnt while en = 0.
REQ-026 SHALL evaluate condex from the pre-update flags when a flag-setting instruction and its own condition occur in the same cycle.

Reset
REQ-027 SHALL, on a rising edge with reset = 1, set flags = RESET_FLAGS and squashcnt = 0, overriding en and flagw.
REQ-028 SHALL keep the strobe outputs combinational during reset cycles, following REQ-017 and REQ-018 from the post-reset flags.
REQ-029 SHALL discard any flag write pending in the same cycle as reset.
REQ-030 SHALL hold no state other than flags and squashcnt.

Verification
REQ-031 SHALL cover: reset, then en=1, cond=1110, flagw=11, aluflags=0100 -> next cycle flags=0100; then cond=0000 gives condex=1 and cond=0001 gives condex=0.
REQ-032 SHALL cover: flags=1000, aluflags=0011, flagw=01, cond=1110 -> flags=1011 (N,Z kept, C,V written).
REQ-033 SHALL cover: flags=0000, cond=0000, regw=1, memw=1, pcs=1, flagw=11 -> all strobes 0, flags unchanged, squashcnt +1.
REQ-034 SHALL cover: flags=1001, cond=1010 -> condex=1; cond=1100 -> condex=1; flags=1000, cond=1011 -> condex=1; regw=1 with nowrite=1 -> regwrite=0.
REQ-035 SHALL cover: CNT_W=4, 20 consecutive cond=1111 with en=1 -> squashcnt=4'hF; then en=0 with cond=1111 -> squashcnt stays F and strobes are 0.
REQ-036 SHALL cover: reset asserted in the same cycle as flagw=11, cond=1110, aluflags=1111 -> flags=RESET_FLAGS, squashcnt=0.
